// File: rtl/stdp_update_sched.sv
// stdp_update_sched: STDP learning controller. Spike timers detect LTP/LTD
// pairings, queue one pending update per synapse, and a round-robin arbiter
// time-shares a single saturating add/sub across the weight register file.
module stdp_update_sched #(
  parameter int unsigned NUM_PRE = 4,
  parameter int unsigned TW      = 4,
  parameter int unsigned WW      = 4,
  parameter int unsigned WINDOW  = 8,
  parameter int unsigned W_INIT  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PRE-1:0]            pre_spike,
  input  logic                          post_spike,
  input  logic                          learn_en,
  output logic [NUM_PRE*WW-1:0]         weight,
  output logic                          update_w_flag,
  output logic [$clog2(NUM_PRE)-1:0]    upd_idx,
  output logic                          upd_ltp,
  output logic [TW-1:0]                 time_diff,
  output logic                          busy
);

  localparam int unsigned IW = $clog2(NUM_PRE);
  localparam logic [TW:0]    LP_WIN   = (TW+1)'(WINDOW);
  localparam logic [TW:0]    LP_HALF  = (TW+1)'(WINDOW / 2);
  localparam logic [WW-1:0]  LP_WINIT = WW'(W_INIT);
  localparam logic [TW-1:0]  LP_TMAX  = '1;

  typedef enum logic {ST_IDLE, ST_APPLY} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_pre_t [NUM_PRE];
  logic [TW-1:0]   r_post_t;
  logic [NUM_PRE-1:0] r_pend;
  logic [NUM_PRE-1:0] r_pol;
  logic [TW-1:0]   r_dt [NUM_PRE];
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_cur_idx;
  logic            r_cur_pol;
  logic [TW-1:0]   r_cur_dt;
  logic [WW-1:0]   r_w [NUM_PRE];
  logic            r_flag;
  logic [IW-1:0]   r_upd_idx;
  logic            r_upd_ltp;
  logic [TW-1:0]   r_time_diff;

  logic [NUM_PRE-1:0] w_ev;
  logic [NUM_PRE-1:0] w_ev_pol;
  logic [TW-1:0]   w_ev_dt [NUM_PRE];
  logic            w_gnt_vld;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_grant;
  logic [WW-1:0]   w_cur_w;
  logic [WW:0]     w_delta;
  logic [WW:0]     w_sum;
  logic [WW:0]     w_diff;
  logic [WW-1:0]   w_new_w;

  // Spike timers: clear on own spike, otherwise saturating count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_post_t <= LP_TMAX;
      for (int unsigned i = 0; i < NUM_PRE; i++) r_pre_t[i] <= LP_TMAX;
    end else begin
      r_post_t <= post_spike ? '0 : ((r_post_t == LP_TMAX) ? LP_TMAX : r_post_t + 1'b1);
      for (int unsigned i = 0; i < NUM_PRE; i++)
        r_pre_t[i] <= pre_spike[i] ? '0 : ((r_pre_t[i] == LP_TMAX) ? LP_TMAX : r_pre_t[i] + 1'b1);
    end
  end

  // Pairing detection against timers registered before this edge
  always_comb begin
    w_ev     = '0;
    w_ev_pol = '0;
    for (int unsigned i = 0; i < NUM_PRE; i++) begin
      w_ev_dt[i] = '0;
      if (learn_en && post_spike && pre_spike[i]) begin
        w_ev[i]     = 1'b1;
        w_ev_pol[i] = 1'b1;
      end else if (learn_en && post_spike && ({1'b0, r_pre_t[i]} < LP_WIN)) begin
        w_ev[i]     = 1'b1;
        w_ev_pol[i] = 1'b1;
        w_ev_dt[i]  = r_pre_t[i];
      end else if (learn_en && pre_spike[i] && !post_spike && ({1'b0, r_post_t} < LP_WIN)) begin
        w_ev[i]     = 1'b1;
        w_ev_dt[i]  = r_post_t;
      end
    end
  end

  // Round-robin pick: first pending synapse at or after the pointer
  always_comb begin
    int unsigned j;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_PRE; k++) begin
      j = (32'(r_ptr) + k) % NUM_PRE;
      if (!w_gnt_vld && r_pend[j]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IW'(j);
      end
    end
  end

  assign w_grant = (r_state == ST_IDLE) && learn_en && w_gnt_vld;

  // Pending queue: new events win over the grant-clear of the same synapse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_pol  <= '0;
      for (int unsigned i = 0; i < NUM_PRE; i++) r_dt[i] <= '0;
    end else if (!learn_en) begin
      r_pend <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PRE; i++) begin
        if (w_ev[i]) begin
          r_pend[i] <= 1'b1;
          r_pol[i]  <= w_ev_pol[i];
          r_dt[i]   <= w_ev_dt[i];
        end else if (w_grant && (w_gnt_idx == IW'(i))) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating add/sub, one bit wider than the weight so nothing wraps
  always_comb begin
    w_cur_w = r_w[r_cur_idx];
    w_delta = ({1'b0, r_cur_dt} < LP_HALF) ? (WW+1)'(2) : (WW+1)'(1);
    w_sum   = {1'b0, w_cur_w} + w_delta;
    w_diff  = {1'b0, w_cur_w} - w_delta;
    if (r_cur_pol) w_new_w = w_sum[WW]  ? '1 : w_sum[WW-1:0];
    else           w_new_w = w_diff[WW] ? '0 : w_diff[WW-1:0];
  end

  // Grant/apply FSM with the weight file and registered update reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cur_idx   <= '0;
      r_cur_pol   <= 1'b0;
      r_cur_dt    <= '0;
      r_flag      <= 1'b0;
      r_upd_idx   <= '0;
      r_upd_ltp   <= 1'b0;
      r_time_diff <= '0;
      for (int unsigned i = 0; i < NUM_PRE; i++) r_w[i] <= LP_WINIT;
    end else begin
      r_flag <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_cur_idx <= w_gnt_idx;
            r_cur_pol <= r_pol[w_gnt_idx];
            r_cur_dt  <= r_dt[w_gnt_idx];
            r_ptr     <= (w_gnt_idx == IW'(NUM_PRE - 1)) ? '0 : w_gnt_idx + 1'b1;
            r_state   <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          r_w[r_cur_idx] <= w_new_w;
          r_upd_idx      <= r_cur_idx;
          r_upd_ltp      <= r_cur_pol;
          r_time_diff    <= r_cur_dt;
          r_flag         <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pack weights, synapse 0 in the most significant slice
  always_comb begin
    weight = '0;
    for (int unsigned i = 0; i < NUM_PRE; i++)
      weight[(NUM_PRE-1-i)*WW +: WW] = r_w[i];
  end

  assign update_w_flag = r_flag;
  assign upd_idx       = r_upd_idx;
  assign upd_ltp       = r_upd_ltp;
  assign time_diff     = r_time_diff;
  assign busy          = (r_state == ST_APPLY) || (|r_pend);

endmodule

// File: tb/tb_stdp_update_sched.sv
// Directed bench for stdp_update_sched: per-cycle vector table plus
// hand-written saturation and reset-during-apply sequences.
module tb_stdp_update_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  pre_spike;
  logic        post_spike;
  logic        learn_en;
  logic [15:0] weight;
  logic        update_w_flag;
  logic [1:0]  upd_idx;
  logic        upd_ltp;
  logic [3:0]  time_diff;
  logic        busy;

  int n_cmp;
  int n_miss;

  stdp_update_sched #(
    .NUM_PRE(4), .TW(4), .WW(4), .WINDOW(8), .W_INIT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .post_spike(post_spike),
    .learn_en(learn_en), .weight(weight), .update_w_flag(update_w_flag),
    .upd_idx(upd_idx), .upd_ltp(upd_ltp), .time_diff(time_diff), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  pre;
    logic        post;
    logic        learn;
    logic [15:0] w;
    logic        flag;
    logic        bsy;
    logic [1:0]  idx;
    logic        ltp;
    logic [3:0]  dt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] p, logic po, logic le, logic [15:0] w,
                              logic f, logic b, logic [1:0] ix, logic lt, logic [3:0] dt);
    vec_t v;
    v.rst = r; v.pre = p; v.post = po; v.learn = le; v.w = w;
    v.flag = f; v.bsy = b; v.idx = ix; v.ltp = lt; v.dt = dt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, settle just after it
  task automatic step(input logic r, input logic [3:0] p, input logic po, input logic le);
    rst_n = r; pre_spike = p; post_spike = po; learn_en = le;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_w;

  initial begin
    n_cmp = 0; n_miss = 0;
    rst_n = 1'b0; pre_spike = '0; post_spike = 1'b0; learn_en = 1'b0;
    #1;

    // A: post alone after reset, pre timers saturated -> nothing happens
    tbl.push_back(mk(0, 4'h0, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 1, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    // B: pre0, post 3 cycles later -> LTP dt 2, delta 2, w0 = 10
    tbl.push_back(mk(0, 4'h0, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h1, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 1, 1, 16'h8888, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8888, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'hA888, 1, 0, 0, 1, 2));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'hA888, 0, 0, 0, 1, 2));
    // C: post, pre1 6 cycles later -> LTD dt 5, delta 1, w1 = 7
    tbl.push_back(mk(0, 4'h0, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 1, 1, 16'h8888, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h2, 0, 1, 16'h8888, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8888, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8788, 1, 0, 1, 0, 5));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8788, 0, 0, 1, 0, 5));
    // D: all pre, post next cycle -> four round-robin writes 2 cycles apart
    tbl.push_back(mk(0, 4'h0, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 1, 1, 16'h8888, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8888, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'hA888, 1, 1, 0, 1, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'hA888, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'hAA88, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'hAA88, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'hAAA8, 1, 1, 2, 1, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'hAAA8, 0, 1, 2, 1, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'hAAAA, 1, 0, 3, 1, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'hAAAA, 0, 0, 3, 1, 0));
    // E: learn_en low blocks capture; dropping it clears a pending event
    tbl.push_back(mk(0, 4'h0, 0, 0, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h1, 0, 0, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 1, 0, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 0, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h1, 0, 1, 16'h8888, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 0, 16'h8888, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 16'h8888, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].pre, tbl[i].post, tbl[i].learn);
      chk($sformatf("row%0d weight", i), weight, tbl[i].w);
      chk($sformatf("row%0d flag", i), {15'b0, update_w_flag}, {15'b0, tbl[i].flag});
      chk($sformatf("row%0d busy", i), {15'b0, busy}, {15'b0, tbl[i].bsy});
      chk($sformatf("row%0d upd_idx", i), {14'b0, upd_idx}, {14'b0, tbl[i].idx});
      chk($sformatf("row%0d upd_ltp", i), {15'b0, upd_ltp}, {15'b0, tbl[i].ltp});
      chk($sformatf("row%0d time_diff", i), {12'b0, time_diff}, {12'b0, tbl[i].dt});
    end

    // LTP saturation on synapse 0 with same-cycle pairs (dt 0, delta 2)
    step(0, 4'h0, 0, 1);
    exp_w = 4'd8;
    for (int n = 0; n < 5; n++) begin
      step(1, 4'h1, 1, 1);
      step(1, 4'h0, 0, 1);
      step(1, 4'h0, 0, 1);
      exp_w = (exp_w > 4'd13) ? 4'd15 : exp_w + 4'd2;
      chk($sformatf("ltpsat%0d w0", n), {12'b0, weight[15:12]}, {12'b0, exp_w});
      chk($sformatf("ltpsat%0d flag", n), {15'b0, update_w_flag}, 16'd1);
      chk($sformatf("ltpsat%0d ltp", n), {15'b0, upd_ltp}, 16'd1);
      chk($sformatf("ltpsat%0d dt", n), {12'b0, time_diff}, 16'd0);
      step(1, 4'h0, 0, 1);
      chk($sformatf("ltpsat%0d flag_low", n), {15'b0, update_w_flag}, 16'd0);
    end

    // LTD saturation on synapse 3: post then pre next cycle (dt 0, delta 2)
    step(0, 4'h0, 0, 1);
    exp_w = 4'd8;
    for (int n = 0; n < 5; n++) begin
      step(1, 4'h0, 1, 1);
      step(1, 4'h8, 0, 1);
      step(1, 4'h0, 0, 1);
      step(1, 4'h0, 0, 1);
      exp_w = (exp_w < 4'd2) ? 4'd0 : exp_w - 4'd2;
      chk($sformatf("ltdsat%0d w3", n), {12'b0, weight[3:0]}, {12'b0, exp_w});
      chk($sformatf("ltdsat%0d flag", n), {15'b0, update_w_flag}, 16'd1);
      chk($sformatf("ltdsat%0d idx", n), {14'b0, upd_idx}, 16'd3);
      chk($sformatf("ltdsat%0d ltp", n), {15'b0, upd_ltp}, 16'd0);
      chk($sformatf("ltdsat%0d others", n), {4'b0, weight[15:4]}, 16'h0888);
      for (int k = 0; k < 10; k++) step(1, 4'h0, 0, 1);
    end

    // Reset asserted while APPLY is in flight
    step(0, 4'h0, 0, 1);
    step(1, 4'h1, 1, 1);
    step(1, 4'h0, 0, 1);
    chk("midapply busy_before", {15'b0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("midapply weight_now", weight, 16'h8888);
    chk("midapply flag_now", {15'b0, update_w_flag}, 16'd0);
    chk("midapply busy_now", {15'b0, busy}, 16'd0);
    step(0, 4'h0, 0, 1);
    chk("midapply weight_edge", weight, 16'h8888);
    chk("midapply flag_edge", {15'b0, update_w_flag}, 16'd0);
    for (int k = 0; k < 3; k++) begin
      step(1, 4'h0, 0, 1);
      chk($sformatf("midapply after%0d weight", k), weight, 16'h8888);
      chk($sformatf("midapply after%0d flag", k), {15'b0, update_w_flag}, 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule

// File: doc/stdp_update_sched.md
# stdp_update_sched

Learning controller for the 4-input STDP synapse datapath. Tracks per-synapse spike timers, detects pre→post (LTP) and post→pre (LTD) pairings inside a timing window, and queues one pending update per synapse. A round-robin arbiter shares a single saturating add/subtract unit across the synapses to read-modify-write a 4×4-bit weight register file. It sits between the spike inputs and the packed weight bus consumed downstream.

## Interface
- NUM_PRE, 4, number of presynaptic inputs
- TW, 4, timer / time-difference width
- WW, 4, weight width
- WINDOW, 8, pairing window in cycles (dt < WINDOW qualifies)
- W_INIT, 8, weight reset value
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- pre_spike  input  NUM_PRE  presynaptic spikes, one bit per synapse
- post_spike  input  1  postsynaptic spike
- learn_en  input  1  enables event capture and grants
- weight  output  NUM_PRE*WW  packed weights; synapse 0 in MSBs (weight[15:12])
- update_w_flag  output  1  one-cycle pulse per weight write
- upd_idx  output  2  synapse of last write
- upd_ltp  output  1  1 = last write was LTP, 0 = LTD
- time_diff  output  TW  dt used by last write
- busy  output  1  state==APPLY or any pending bit set

## Operation
- Timers: pre_t[i], post_t; cleared to 0 on own spike, else +1 saturating at 2^TW-1. Reset value 2^TW-1 (no recent spike).
- All event checks use timer values registered before the current edge.
- LTP: post_spike & learn_en: for each i with pre_t[i] < WINDOW, set pend[i], pol[i]=1, dt[i]=pre_t[i].
- LTD: pre_spike[i] & learn_en & !post_spike & post_t < WINDOW: set pend[i], pol[i]=0, dt[i]=post_t.
- Same-cycle pre_spike[i] and post_spike: LTP with dt=0 (overrides the timer-based check); no LTD.
- New event on an already-pending synapse overwrites pol/dt (latest wins).
- Delta: 2 if dt < WINDOW/2, else 1.
- LTP: w = min(w+delta, 2^WW-1). LTD: w = max(w-delta, 0). Adder one bit wider than WW; no wrap.
- Arbiter: round-robin over pend, pointer resets to 0; after a grant, pointer = granted+1 mod NUM_PRE.
- FSM IDLE: if learn_en & |pend: latch idx/pol/dt of the winner, clear pend[idx], go to APPLY. If an event for idx arrives on the same edge, pend[idx] stays set with the new data.
- FSM APPLY: write weights[idx], register upd_idx/upd_ltp/time_diff, pulse update_w_flag, return to IDLE.
- learn_en=0: clears all pend and blocks grants. An in-flight APPLY completes. Timers keep running.

## Timing
- Reset values: weights all W_INIT (weight=16'h8888), update_w_flag 0, upd_idx 0, upd_ltp 0, time_diff 0, busy 0, state IDLE, pend 0, pointer 0.
- Latency: event sampled at edge k sets pend; grant at edge k+1; write at edge k+2. update_w_flag and the new weight are visible in the cycle after edge k+2.
- Throughput: one write per 2 cycles. update_w_flag is never high two consecutive cycles.
- weight is registered directly from the register file; no combinational path from inputs.
- rst_n low mid-APPLY: all state returns to reset values immediately; no write occurs.

## Test plan
- Reset, then post_spike alone → no flag, weight stays 16'h8888 (pre timers saturated at 15 ≥ 8).
- pre_spike=0001, post_spike 3 cycles later → flag 2 cycles after post, upd_idx 0, upd_ltp 1, time_diff 2, weight[15:12]=10.
- post_spike, then pre_spike=0010 6 cycles later → upd_ltp 0, time_diff 5, delta 1, weight[11:8]=7.
- pre_spike=1111 with post_spike the next cycle → four flags spaced 2 cycles apart, upd_idx 0,1,2,3, time_diff 0, weight=16'hAAAA. busy deasserts after the last flag.
- Saturation: repeated pre/post pairs take weight[15:12] to 15 and hold it there. Repeated post/pre pairs on synapse 3 take it to 0 and hold it there. Same-cycle pre/post gives dt=0, delta 2.
- Assert rst_n low during APPLY, and separately hold learn_en=0 during spikes → reset gives weight 16'h8888 and flag 0 immediately; learn_en=0 gives no pend and no flags.
